// File: rtl/ddr3_wr_dma_ch.sv
// Write-DMA channel: drains a FWFT write FIFO into the MIG native app interface
// in BURST_LEN-beat bursts, one arbiter grant per burst, over a circular frame region.
//
// state | meaning
// IDLE  | waiting for enable and a full burst buffered in the FIFO
// REQ   | arbiter request held until the grant level is sampled
// START | one-cycle start pulse to the arbiter
// BURST | one command+data beat per cycle with both MIG readies high
// END   | one-cycle end pulse; frame wrap handled here
module ddr3_wr_dma_ch #(
    parameter int DATA_W      = 128,
    parameter int ADDR_W      = 28,
    parameter int CNT_W       = 10,
    parameter int BURST_LEN   = 64,
    parameter int ADDR_STEP   = 8,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_BEATS = 4096
) (
    input  logic                I_clk,
    input  logic                I_Rst,
    input  logic                I_enable,
    input  logic [CNT_W-1:0]    I_fifo_cnt,
    input  logic [DATA_W-1:0]   I_fifo_dout,
    output logic                O_fifo_rd_en,
    output logic                O_ch_req,
    input  logic                I_ch_vaild,
    output logic                O_ch_start,
    output logic                O_ch_end,
    output logic [ADDR_W-1:0]   O_app_addr,
    output logic [2:0]          O_app_cmd,
    output logic                O_app_en,
    input  logic                I_app_rdy,
    output logic [DATA_W-1:0]   O_app_wdf_data,
    output logic                O_app_wdf_wren,
    output logic                O_app_wdf_end,
    output logic [DATA_W/8-1:0] O_app_wdf_mask,
    input  logic                I_app_wdf_rdy,
    output logic                O_frame_done,
    output logic                O_busy
);

    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int FRM_W  = $clog2(FRAME_BEATS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_START,
        S_BURST,
        S_END
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [BEAT_W-1:0] r_beat;
    logic [FRM_W-1:0]  r_frame;

    logic w_fire;
    logic w_last_beat;
    logic w_frame_end;
    logic w_have_burst;

    assign w_fire       = (r_state == S_BURST) && I_app_rdy && I_app_wdf_rdy;
    assign w_last_beat  = (r_beat == BEAT_W'(BURST_LEN - 1));
    assign w_frame_end  = (r_frame == FRM_W'(FRAME_BEATS));
    assign w_have_burst = (I_fifo_cnt >= CNT_W'(BURST_LEN));

    always_ff @(posedge I_clk) begin
        if (I_Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (I_enable && w_have_burst) w_next = S_REQ;
            // enable is deliberately ignored here: a raised request is never withdrawn
            S_REQ:   if (I_ch_vaild) w_next = S_START;
            S_START: w_next = S_BURST;
            S_BURST: if (w_fire && w_last_beat) w_next = S_END;
            S_END:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Beat counter spans one burst; frame counter spans the whole frame in beats.
    always_ff @(posedge I_clk) begin
        if (I_Rst) begin
            r_addr  <= ADDR_W'(BASE_ADDR);
            r_beat  <= '0;
            r_frame <= '0;
        end else if (w_fire) begin
            r_addr  <= r_addr + ADDR_W'(ADDR_STEP);
            r_beat  <= r_beat + BEAT_W'(1);
            r_frame <= r_frame + FRM_W'(1);
        end else if (r_state == S_END) begin
            r_beat <= '0;
            if (w_frame_end) begin
                r_addr  <= ADDR_W'(BASE_ADDR);
                r_frame <= '0;
            end
        end
    end

    always_comb begin
        O_ch_req       = 1'b0;
        O_ch_start     = 1'b0;
        O_ch_end       = 1'b0;
        O_frame_done   = 1'b0;
        O_busy         = 1'b0;
        O_app_en       = 1'b0;
        O_app_wdf_wren = 1'b0;
        O_app_wdf_end  = 1'b0;
        O_fifo_rd_en   = 1'b0;
        O_app_wdf_data = '0;
        O_app_cmd      = 3'b000;
        O_app_wdf_mask = '0;
        O_app_addr     = r_addr;
        O_busy         = (r_state != S_IDLE);
        O_ch_req       = (r_state == S_REQ);
        O_ch_start     = (r_state == S_START);
        O_ch_end       = (r_state == S_END);
        O_frame_done   = (r_state == S_END) && w_frame_end;
        O_app_en       = w_fire;
        O_app_wdf_wren = w_fire;
        O_app_wdf_end  = w_fire;
        O_fifo_rd_en   = w_fire;
        // data is zeroed outside BURST so the MIG bus is quiet when idle
        if (r_state == S_BURST) O_app_wdf_data = I_fifo_dout;
    end

endmodule

// File: doc/ddr3_wr_dma_ch.md
Name: ddr3_wr_dma_ch

Overview:
- Write-DMA channel controller that drains a local write-data FIFO into DDR3 through the MIG native app interface.
- Sits directly upstream of the two-channel DMA arbiter and occupies one arbiter channel port.
- Raises a request when a full burst is buffered, waits for the grant, pulses start, and streams BURST_LEN command+data beats.
- Pulses end when the burst completes; the write address walks a circular frame region.

Parameters:
DATA_W, 128, app data width (MIG UI width)
ADDR_W, 28, app_addr width
CNT_W, 10, width of FIFO fill count
BURST_LEN, 64, beats per arbitration grant; range 4..2^CNT_W-1
ADDR_STEP, 8, app_addr increment per beat (BL8)
BASE_ADDR, 0, first address of frame region
FRAME_BEATS, 4096, beats per frame; must be a multiple of BURST_LEN

Ports:
I_clk  in  1  single clock, shared with arbiter and MIG UI clock
I_Rst  in  1  synchronous, active-high reset
I_enable  in  1  level; 0 stops new requests (burst in progress completes)
I_fifo_cnt  in  CNT_W  words in write FIFO
I_fifo_dout  in  DATA_W  FWFT head word, valid when I_fifo_cnt>0
O_fifo_rd_en  out  1  pop head word
O_ch_req  out  1  arbiter request
I_ch_vaild  in  1  arbiter grant level
O_ch_start  out  1  one-cycle start pulse to arbiter
O_ch_end  out  1  one-cycle end pulse to arbiter
O_app_addr  out  ADDR_W  command address
O_app_cmd  out  3  always 3'b000 (write)
O_app_en  out  1  command valid
I_app_rdy  in  1  MIG command ready
O_app_wdf_data  out  DATA_W  write data
O_app_wdf_wren  out  1  write data valid
O_app_wdf_end  out  1  equals O_app_wdf_wren (one UI word per BL8 in 4:1 mode)
O_app_wdf_mask  out  DATA_W/8  constant 0
I_app_wdf_rdy  in  1  MIG write-data ready
O_frame_done  out  1  one-cycle pulse after last burst of a frame
O_busy  out  1  high in any state except IDLE

Behaviour:
- Clocking and reset: one clock, I_clk. Reset is synchronous and active-high on I_Rst.
- Reset values:
  - State IDLE.
  - Address register = BASE_ADDR; beat and frame counters = 0.
  - All outputs 0 except O_app_cmd=3'b000 and O_app_addr=BASE_ADDR.
- Reset mid-burst: abandons the burst immediately and no end pulse is issued. The arbiter shares this reset, so both sides return to idle together.
- State machine:
  - IDLE: go to REQ when I_enable=1 and I_fifo_cnt>=BURST_LEN.
  - REQ: O_ch_req=1 (registered). Go to START on the first cycle I_ch_vaild=1 is sampled. The request cannot be withdrawn; I_enable falling in REQ is ignored.
  - START: O_ch_start=1 for exactly this one cycle; O_ch_req=0. Next state BURST unconditionally.
  - BURST: one beat fires in each cycle where I_app_rdy=1 and I_app_wdf_rdy=1.
    - In a firing cycle, O_app_en, O_app_wdf_wren, O_app_wdf_end and O_fifo_rd_en are all 1. They are combinational from (state==BURST & I_app_rdy & I_app_wdf_rdy).
    - O_app_wdf_data=I_fifo_dout. O_app_addr is the registered current address.
    - On a fire: address += ADDR_STEP and beat count += 1.
    - After fire number BURST_LEN, go to END.
    - No beat fires when either ready is 0; all strobes stay 0 and the address holds.
  - END: O_ch_end=1 for one cycle; beat count clears; next state IDLE.
    - If this burst completed FRAME_BEATS total beats: O_frame_done=1 in the same cycle, the address reloads to BASE_ADDR, and the frame counter clears.
- Arbiter timing:
  - The arbiter edge-detects start through two flops and accepts end only after that edge registers.
  - Start at cycle T is followed by end no earlier than T+1+BURST_LEN, which is >= T+5, so this is always legal.
  - The arbiter re-arbitrates the cycle after end; IDLE may re-request on the next cycle.
- FIFO: the threshold check guarantees BURST_LEN words are present, so underflow in BURST is impossible. Words arriving during BURST are not counted toward the current burst.
- Address arithmetic: ADDR_W-bit unsigned; wrap only at frame boundary, never mid-burst. The last address of a frame is BASE_ADDR+(FRAME_BEATS-1)*ADDR_STEP.
- Simultaneous events: a rdy deassertion on the final beat delays END; END is never skipped.

Test Plan:
- Reset: assert I_Rst 3 cycles mid-BURST (beat 10) -> next cycle state IDLE, all strobes 0, O_app_addr=0, no O_ch_end pulse.
- Threshold: I_fifo_cnt=63 then 64 with I_enable=1 -> O_ch_req rises exactly one cycle after cnt reaches 64, never at 63.
- Handshake with real arbiter: I_ch_vaild high at cycle N -> O_ch_start single pulse at N+1; 64 beats with rdy tied 1; O_ch_end single pulse at N+66; arbiter returns to idle.
- Backpressure: I_app_wdf_rdy random 50% -> exactly 64 fires, 64 pops, addresses 0,8,...,504 in order with no duplicates, data matches FIFO order.
- Frame wrap: FRAME_BEATS=128, run 3 bursts -> addresses 0..504, 512..1016, then 0 again; O_frame_done pulses with the second O_ch_end only.
- Enable drop in REQ: deassert I_enable while requesting -> burst still completes, then O_ch_req stays 0 while I_enable=0.
